// File: rtl/nw_pkg.sv
// ============================================================================
// Module : nw_pkg
// Purpose: Shared types, constants and sizing helpers for the
//          Needleman-Wunsch datapath (score width, matrix depth,
//          address width, address range check).
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nw_pkg;

  // Width of one signed alignment score
  localparam int SCORE_W = 9;

  // Number of entries in an (n+1)x(n+1) score matrix
  function automatic int depth_f(input int n);
    return (n + 1) * (n + 1);
  endfunction

  // Address port width; one bit wider than strictly needed so that
  // out-of-range addresses can be presented and rejected
  function automatic int addr_w_f(input int n);
    return $clog2(depth_f(n) - 1) + 1;
  endfunction

  // True when addr selects a real matrix entry
  function automatic logic addr_in_range(input int addr, input int depth);
    return (addr >= 0) && (addr < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scores_ram.sv
// ============================================================================
// Module : scores_ram
// Purpose: Register-array storage for the (N+1)x(N+1) signed score matrix,
//          row-major. Synchronous write, registered 1-cycle read, read-first
//          on same-address collisions. Out-of-range writes are dropped and
//          out-of-range reads return zero.
// Ports  : clk        - clock, all state on rising edge
//          rst        - asynchronous active-low reset (clears dout and memory)
//          din        - signed score to write
//          en_din     - write-port enable
//          we         - write strobe (write needs en_din & we)
//          addr_din   - write address
//          en_dout    - read-port enable (dout holds when low)
//          addr_dout  - read address
//          dout       - registered signed read data
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scores_ram
  import nw_pkg::*;
#(
  parameter int N           = 5,
  parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SCORE_W-1:0] din,
  input  logic                      en_din,
  input  logic                      we,
  input  logic [addr_lenght:0]      addr_din,
  input  logic                      en_dout,
  input  logic [addr_lenght:0]      addr_dout,
  output logic signed [SCORE_W-1:0] dout
);

  localparam int DEPTH = depth_f(N);
  // Bits actually needed to index the array; upper address bits only
  // matter for the range check
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [SCORE_W-1:0] r_mem [DEPTH];
  logic signed [SCORE_W-1:0] r_dout;

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = en_din && we && addr_in_range(int'(addr_din), DEPTH);
  assign w_rd_ok = addr_in_range(int'(addr_dout), DEPTH);

  // Read and write share one block so that the read samples the array
  // before the write's non-blocking update lands (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_mem[addr_din[IDX_W-1:0]] <= din;
      end
      if (en_dout) begin
        r_dout <= w_rd_ok ? r_mem[addr_dout[IDX_W-1:0]] : '0;
      end
    end
  end

  assign dout = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_scores_ram.sv
// ============================================================================
// Module : tb_scores_ram
// Purpose: Self-checking bench for scores_ram. A behavioural matrix model
//          predicts each cycle's dout; predictions are queued when stimulus
//          is applied and compared after the clock edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scores_ram;
  import nw_pkg::*;

  localparam int N     = 5;
  localparam int AW    = $clog2(((N + 1) * (N + 1)) - 1);
  localparam int DEPTH = (N + 1) * (N + 1);

  logic                      clk;
  logic                      rst;
  logic signed [SCORE_W-1:0] din;
  logic                      en_din;
  logic                      we;
  logic [AW:0]               addr_din;
  logic                      en_dout;
  logic [AW:0]               addr_dout;
  logic signed [SCORE_W-1:0] dout;

  scores_ram #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .en_din    (en_din),
    .we        (we),
    .addr_din  (addr_din),
    .en_dout   (en_dout),
    .addr_dout (addr_dout),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [SCORE_W-1:0] val;
    string                     name;
  } sb_t;

  sb_t                       sb_q[$];
  logic signed [SCORE_W-1:0] m_mem [DEPTH];
  logic signed [SCORE_W-1:0] last_exp;
  int                        n_checks;
  int                        n_fail;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    last_exp = '0;
  endtask

  // One clock of stimulus; the expected dout is pushed before the model
  // applies the write, giving read-first semantics on collisions.
  task automatic step(input logic ed, input logic w, input int wa, input int wd,
                      input logic er, input int ra, input string name);
    sb_t e;
    sb_t g;
    int  wdv;
    wdv       = wd;
    en_din    = ed;
    we        = w;
    addr_din  = wa[AW:0];
    din       = wdv[SCORE_W-1:0];
    en_dout   = er;
    addr_dout = ra[AW:0];
    if (!rst) begin
      e.val = '0;
    end else if (er) begin
      e.val = (ra >= 0 && ra < DEPTH) ? m_mem[ra] : '0;
    end else begin
      e.val = last_exp;
    end
    e.name = name;
    sb_q.push_back(e);
    if (rst && ed && w && wa >= 0 && wa < DEPTH) m_mem[wa] = wdv[SCORE_W-1:0];
    last_exp = e.val;
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    n_checks++;
    if (dout !== g.val) begin
      n_fail++;
      $display("FAIL %s: dout=%0d expected=%0d", g.name, dout, g.val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, "reset_hold");
    rst = 1'b1;
    step(0, 0, 0, 0, 1, 0,  "reset_addr0");
    step(0, 0, 0, 0, 1, 35, "reset_addr35");
  endtask

  task automatic test_basic();
    step(1, 1, 0, 1, 0, 0, "basic_wr0");
    step(1, 1, 1, 5, 0, 0, "basic_wr1");
    step(0, 0, 0, 0, 1, 0, "basic_rd0");
    step(0, 0, 0, 0, 1, 1, "basic_rd1");
  endtask

  task automatic test_boundary();
    step(1, 1, 35, -256, 0, 0,  "bnd_wr35");
    step(1, 1, 34, 255,  0, 0,  "bnd_wr34");
    step(1, 1, 36, 7,    1, 35, "bnd_wr36_rd35");
    step(0, 0, 0,  0,    1, 34, "bnd_rd34");
    step(0, 0, 0,  0,    1, 36, "bnd_rd36");
    step(0, 0, 0,  0,    1, 0,  "bnd_rd0");
    step(0, 0, 0,  0,    1, 127, "bnd_rd127");
  endtask

  task automatic test_gating();
    step(1, 0, 2, 9, 0, 0, "gate_we0");
    step(0, 1, 2, 9, 0, 0, "gate_en0");
    step(0, 0, 0, 0, 1, 2, "gate_rd2");
    step(0, 0, 0, 0, 1, 1, "gate_rd1");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 30 + i, "gate_hold");
  endtask

  task automatic test_read_during_write();
    step(1, 1, 3, 4, 0, 0, "rdw_prep");
    step(1, 1, 3, 8, 1, 3, "rdw_old");
    step(0, 0, 0, 0, 1, 3, "rdw_new");
  endtask

  task automatic test_back_to_back();
    // Both ports busy every cycle; reads trail writes by one address
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 1, i, (i * 37 % 511) - 255, 1, (i + DEPTH - 1) % DEPTH, "b2b");
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) step(1, 1, i, 10 + i, 0, 0, "mid_fill");
    step(0, 0, 0, 0, 1, 5, "mid_rd5");
    rst = 1'b0;
    #2;
    n_checks++;
    if (dout !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: dout=%0d expected=0", dout);
    end
    model_clear();
    step(0, 0, 0, 0, 1, 5, "mid_in_reset");
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, i, "mid_clear");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    din       = '0;
    en_din    = 1'b0;
    we        = 1'b0;
    addr_din  = '0;
    en_dout   = 1'b0;
    addr_dout = '0;
    model_clear();
    #1;
    test_reset();
    test_basic();
    test_boundary();
    test_gating();
    test_read_during_write();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scores_ram.md
Name: scores_ram

Overview:
- Score-matrix storage for the Needleman-Wunsch datapath.
- One write port (fed by init/insert logic; en_din = en_init | en_ins) and one read port (fed by traceback/compute logic).
- Holds (N+1)x(N+1) signed 9-bit alignment scores, row-major.
- Register-array RAM; synchronous write, registered (1-cycle) read.

Parameters:
- N, 5, sequence length; matrix is (N+1)x(N+1).
- addr_lenght, $clog2(((N+1)*(N+1))-1), derived, not overridden; address ports are addr_lenght+1 bits wide (7 bits for N=5).
- DEPTH (localparam), (N+1)*(N+1), number of entries (36 for N=5).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  9 signed  score to write.
- en_din  input  1  write-port enable.
- we  input  1  write strobe; a write occurs only when en_din=1 and we=1.
- addr_din  input  addr_lenght+1  write address.
- en_dout  input  1  read-port enable.
- addr_dout  input  addr_lenght+1  read address.
- dout  output  9 signed  registered read data.

Behaviour:
- Reset (rst=0, asynchronous): dout=0; every entry mem[0..DEPTH-1]=0. Reset has priority over any write or read in flight; a write coinciding with reset assertion is discarded. State remains cleared while rst=0.
- Write:
  - On posedge clk with rst=1, en_din=1, we=1 and addr_din<DEPTH: mem[addr_din] <= din.
  - If en_din=0 or we=0: no write.
  - If addr_din>=DEPTH: write is silently ignored; no wrap-around.
- Read:
  - On posedge clk with rst=1 and en_dout=1: dout <= mem[addr_dout] if addr_dout<DEPTH, else 0.
  - Latency is 1 cycle from address/enable to dout.
  - en_dout=0: dout holds its last value.
- Same-address write and read in one cycle: read-first; dout returns the old contents, and the new value is visible on the next read.
- Write and read ports are fully independent; both may be active every cycle.
- Data is two's complement and stored and returned bit-exact; no saturation or sign manipulation.
- No combinational path from any input to dout.

Decomposition:
- Shared package (nw_pkg): SCORE_W=9; function for DEPTH(N); address-width function matching $clog2((N+1)^2-1)+1.
- No sub-module required.
- An optional address-range check helper (addr_in_range function) lives in the package, not as a module.

Test Plan:
- Reset: hold rst=0 for 5 cycles with en_dout=1 at addr_dout=0 -> dout=0; after release, read addr 0 and addr 35 -> dout=0.
- Basic write/read:
  - Write din=1 at addr 0, then din=5 at addr 1 (en_din=1, we=1).
  - Then set en_din=0, we=0, en_dout=1 and read addr 0, then addr 1.
  - Required: dout=1, then dout=5, each one cycle after the address is applied.
- Negative and boundary data: write -256 at addr 35 and +255 at addr 34 -> reads return -256 and 255 exactly. Write addr 36 (out of range) with din=7 -> read addr 36 gives 0 and addr 0 is unchanged.
- Gating:
  - en_din=1, we=0, din=9 at addr 2 -> addr 2 stays 0.
  - en_din=0, we=1 -> no write.
  - With en_dout=0 and the address changing, dout holds its previous value.
- Read-during-write: addr 3 holds 4; in one cycle write 8 to addr 3 and read addr 3 -> dout=4; next cycle's read -> dout=8.
- Mid-operation reset: after filling addrs 0..5, pulse rst=0 between clock edges -> dout drops to 0 immediately; all entries read back 0 after release.
